// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART transmitter signals of the tx arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               busy;
  logic [2:0]         active_id;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic               tx_done;

  modport master (
    input  req, req_data, tx_busy, tx_done,
    output grant, done, err, busy, active_id, tx_start, tx_data
  );

  modport slave (
    output req, req_data, tx_busy, tx_done,
    input  grant, done, err, busy, active_id, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N_REQ requesters
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    last_ptr, active_id, winner;
  logic [IW-1:0] sel;
  logic [7:0]    tx_data_q, win_byte;
  logic [CW-1:0] cnt;
  logic          found, go, waiting, timed_out;

  // First requesting index after last_ptr, wrapping around.
  always_comb begin
    sel    = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      sel = IW'((int'(last_ptr) + k) % N_REQ);
      if (!found && bus.req[sel]) begin
        found  = 1'b1;
        winner = 3'(sel);
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (winner == 3'(i)) win_byte = bus.req_data[8*i +: 8];
  end

  // grant is decided combinationally in IDLE; reset gates it so it is 0 while reset is held.
  assign go        = found && !bus.tx_busy && !reset;
  assign waiting   = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timed_out = (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.grant    = '0;
    bus.done     = '0;
    bus.err      = 1'b0;
    bus.tx_start = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          bus.grant = N_REQ'(1) << winner;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.tx_start = 1'b1;
        state_nxt    = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        // A completion seen in the same cycle as the timeout still counts as done.
        if (bus.tx_done) begin
          bus.done  = N_REQ'(1) << active_id;
          state_nxt = IDLE;
        end else if (timed_out) begin
          bus.err   = 1'b1;
          state_nxt = IDLE;
        end else if (state == WAIT_BUSY && bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ptr  <= 3'(N_REQ - 1);
      active_id <= '0;
      tx_data_q <= '0;
      cnt       <= '0;
    end else begin
      if (state == IDLE && go) begin
        active_id <= winner;
        tx_data_q <= win_byte;
      end
      if (state == ISSUE)  cnt <= '0;
      else if (waiting)    cnt <= cnt + CW'(1);
      if (waiting && (bus.tx_done || timed_out)) last_ptr <= active_id;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.tx_data   = tx_data_q;
  assign bus.active_id = active_id;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a UART transmitter model
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0, n_fail = 0, cyc = 0, viol = 0;
  logic bfm_en = 1'b1, bfm_busy = 1'b0, bfm_done = 1'b0, force_busy = 1'b0, bfm_active = 1'b0;
  int   bfm_nb = -1;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  assign bus.tx_busy = bfm_busy | force_busy;
  assign bus.tx_done = bfm_done;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!reset && ((bus.grant != '0 && bus.busy) || (bus.tx_start && !bus.busy))) viol <= viol + 1;

  // Transmitter model: after tx_start, optionally busy for nb cycles, then a one-cycle tx_done.
  initial begin
    forever begin
      @(negedge clk);
      if (bfm_en && bus.tx_start && !reset) begin
        int nb;
        nb = (bfm_nb >= 0) ? bfm_nb : int'($urandom_range(0, 3));
        bfm_active = 1'b1;
        @(posedge clk); #1;
        if (nb > 0) begin
          bfm_busy = 1'b1;
          repeat (nb) begin @(posedge clk); #1; end
        end
        bfm_busy = 1'b0;
        bfm_done = 1'b1;
        @(posedge clk); #1;
        bfm_done   = 1'b0;
        bfm_active = 1'b0;
      end
    end
  end

  function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.grant != '0 || bus.done != '0 || bus.err) break;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy && !bfm_active) break;
    end
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 50 && bfm_active; i++) @(posedge clk);
    drive_edge();
    reset = 1'b1; bus.req = '0; bus.req_data = '0; force_busy = 1'b0; bfm_en = 1'b1; bfm_nb = -1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_edge();
    reset = 1'b1; bus.req = 4'b1111; bus.req_data = 32'h4433_2211;
    @(negedge clk);
    n_tests++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
    n_tests++; if (bus.done !== 4'b0000) begin n_fail++; $display("FAIL reset_done got %b want 0000", bus.done); end
    n_tests++; if ({bus.err, bus.busy, bus.tx_start} !== 3'b000) begin n_fail++; $display("FAIL reset_err_busy_start got %b want 000", {bus.err, bus.busy, bus.tx_start}); end
    n_tests++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_tests++; if (bus.active_id !== 3'd0) begin n_fail++; $display("FAIL reset_active_id got %0d want 0", bus.active_id); end
    drive_edge();
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b want 0001", bus.grant); end
    drive_edge();
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_single();
    logic hold_bad;
    apply_reset();
    drive_edge();
    bus.req = 4'b0100; bus.req_data = 32'h33A5_2211;
    wait_out(20);
    n_tests++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", bus.grant); end
    drive_edge();
    bus.req = '0; bus.req_data = $urandom;
    @(negedge clk);
    n_tests++; if ({bus.tx_start, bus.tx_data} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL single_issue got start=%b data=%h want start=1 data=a5", bus.tx_start, bus.tx_data); end
    n_tests++; if (bus.active_id !== 3'd2) begin n_fail++; $display("FAIL single_active_id got %0d want 2", bus.active_id); end
    hold_bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.tx_data !== 8'hA5) hold_bad = 1'b1;
      if (bus.done != '0 || bus.err) break;
    end
    n_tests++; if (bus.done !== 4'b0100) begin n_fail++; $display("FAIL single_done got %b want 0100", bus.done); end
    n_tests++; if (hold_bad !== 1'b0) begin n_fail++; $display("FAIL single_data_hold got changed=%b want 0", hold_bad); end
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", bus.busy); end
    wait_idle();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] gq[$];
    int           gc[$];
    logic [7:0]   rq[$];
    logic [N-1:0] eg, g;
    logic [7:0]   rb;
    int           ptr, w;
    apply_reset();
    drive_edge();
    bus.req = 4'b1111; bus.req_data = 32'h1312_1110;
    for (int i = 0; i < 200 && rq.size() < 5; i++) begin
      @(negedge clk);
      if (bus.grant != '0) begin gq.push_back(bus.grant); gc.push_back(cyc); end
      if (bus.tx_start) rq.push_back(bus.tx_data);
    end
    drive_edge();
    bus.req = '0;
    wait_idle();
    ptr = N - 1;
    for (int i = 0; i < 5; i++) begin
      w  = rr_pick(ptr, 4'b1111);
      eg = '0; eg[w] = 1'b1;
      g  = (i < gq.size()) ? gq[i] : '0;
      rb = (i < rq.size()) ? rq[i] : 8'hxx;
      n_tests++; if (g !== eg) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", i, g, eg); end
      n_tests++; if (rb !== 8'h10 + 8'(w)) begin n_fail++; $display("FAIL rr_byte[%0d] got %h want %h", i, rb, 8'h10 + 8'(w)); end
      if (i > 0 && i < gc.size()) begin
        n_tests++; if (gc[i] - gc[i-1] < 3) begin n_fail++; $display("FAIL rr_gap[%0d] got %0d want >=3", i, gc[i] - gc[i-1]); end
      end
      ptr = w;
    end
  endtask

  task automatic test_single_requester();
    apply_reset();
    drive_edge();
    bus.req = 4'b0010; bus.req_data = 32'h0000_7700;
    for (int t = 0; t < 3; t++) begin
      wait_out(20);
      n_tests++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL solo_grant[%0d] got %b want 0010", t, bus.grant); end
      @(negedge clk);
      n_tests++; if (bus.tx_data !== 8'h77) begin n_fail++; $display("FAIL solo_byte[%0d] got %h want 77", t, bus.tx_data); end
      wait_out(20);
    end
    drive_edge();
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_blocked();
    logic early;
    apply_reset();
    drive_edge();
    force_busy = 1'b1; bus.req = 4'b0001; bus.req_data = 32'h0000_00C3;
    early = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.grant != '0) early = 1'b1;
    end
    n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL blocked_no_grant got granted=%b want 0", early); end
    drive_edge();
    force_busy = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL blocked_release_grant got %b want 0001", bus.grant); end
    drive_edge();
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_timeout();
    int   t0;
    logic saw_done;
    apply_reset();
    drive_edge();
    bfm_en = 1'b0; bus.req = 4'b0001; bus.req_data = 32'h0000_005A;
    wait_out(20);
    drive_edge();
    bus.req = '0;
    @(negedge clk);
    n_tests++; if (bus.tx_start !== 1'b1) begin n_fail++; $display("FAIL to_start got %b want 1", bus.tx_start); end
    t0 = cyc;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done != '0) saw_done = 1'b1;
      if (bus.err) break;
    end
    n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", bus.err); end
    n_tests++; if (cyc - t0 !== TO) begin n_fail++; $display("FAIL to_latency got %0d want %0d", cyc - t0, TO); end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL to_no_done got %b want 0", saw_done); end
    drive_edge();
    bfm_en = 1'b1; bus.req = 4'b0011;
    @(negedge clk);
    n_tests++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL to_next_grant got %b want 0010", bus.grant); end
    drive_edge();
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_mid_reset();
    logic pulse;
    apply_reset();
    drive_edge();
    bfm_nb = 10; bus.req = 4'b0100; bus.req_data = 32'h003C_0000;
    wait_out(20);
    drive_edge();
    bus.req = '0;
    repeat (3) @(negedge clk);
    n_tests++; if ({bus.busy, bus.active_id} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL mid_pre_state got busy=%b id=%0d want busy=1 id=2", bus.busy, bus.active_id); end
    #1 reset = 1'b1;
    #1;
    n_tests++; if ({bus.grant, bus.done, bus.err, bus.busy, bus.tx_start, bus.tx_data, bus.active_id} !== '0)
      begin n_fail++; $display("FAIL mid_outputs_zero got %h want 0", {bus.grant, bus.done, bus.err, bus.busy, bus.tx_start, bus.tx_data, bus.active_id}); end
    pulse = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done != '0 || bus.err) pulse = 1'b1;
    end
    n_tests++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse got %b want 0", pulse); end
    drive_edge();
    bfm_nb = -1; reset = 1'b0; bus.req = 4'b1001;
    @(negedge clk);
    n_tests++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL mid_after_grant got %b want 0001", bus.grant); end
    drive_edge();
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_random();
    logic [7:0]   bytes[N];
    logic [N-1:0] m, eg;
    logic         hold_bad;
    int           ptr, w;
    apply_reset();
    ptr = N - 1;
    for (int t = 0; t < 16; t++) begin
      drive_edge();
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        bytes[i] = 8'($urandom);
        bus.req_data[8*i +: 8] = bytes[i];
      end
      bus.req = m;
      w  = rr_pick(ptr, m);
      eg = '0; eg[w] = 1'b1;
      wait_out(20);
      n_tests++; if (bus.grant !== eg) begin n_fail++; $display("FAIL rand_grant[%0d] got %b want %b req=%b", t, bus.grant, eg, m); end
      drive_edge();
      if ($urandom_range(0, 1) == 1) bus.req = '0;
      bus.req_data = $urandom;
      @(negedge clk);
      n_tests++; if ({bus.tx_start, bus.tx_data} !== {1'b1, bytes[w]}) begin n_fail++; $display("FAIL rand_issue[%0d] got start=%b data=%h want start=1 data=%h", t, bus.tx_start, bus.tx_data, bytes[w]); end
      hold_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.tx_data !== bytes[w]) hold_bad = 1'b1;
        if (bus.done != '0 || bus.err) break;
      end
      n_tests++; if ({bus.done, hold_bad} !== {eg, 1'b0}) begin n_fail++; $display("FAIL rand_done[%0d] got done=%b changed=%b want done=%b changed=0", t, bus.done, hold_bad, eg); end
      ptr = w;
    end
    drive_edge();
    bus.req = '0;
    wait_idle();
    n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL protocol_violations got %0d want 0", viol); end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_single_requester();
    test_blocked();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
